pip_reg_chain: RTL and testbench

PIP_REG_CHAIN -- requirements
Module: pip_reg_chain

---
 rtl/pip_reg_chain.sv | 114 +++++++++++
 tb/tb_pip_reg_chain.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pip_reg_chain.sv
`default_nettype none
// ============================================================================
// Module   : pip_reg_chain
// Brief    : Valid/ready register pipeline with per-stage stall and flush,
//            bubble collapse, occupancy and a saturating kill counter.
// Revision : 1.0
// ============================================================================
module pip_reg_chain #(
    parameter int WIDTH        = 32,
    parameter int STAGES       = 4,
    parameter int ZERO_INVALID = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [STAGES-1:0]           stall,
    input  logic [STAGES-1:0]           flush,
    input  logic                        out_ready,
    output logic [STAGES*WIDTH-1:0]     stage_data,
    output logic [STAGES-1:0]           stage_valid,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [15:0]                 kill_count
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [STAGES-1:0][WIDTH-1:0] w_next_data;
    logic [STAGES-1:0]            r_valid;
    logic [STAGES-1:0]            w_next_valid;
    logic [STAGES-1:0]            w_hold;
    logic [15:0]                  r_kill_count;
    logic [15:0]                  w_next_kill;
    logic [4:0]                   w_kill_num;
    logic [16:0]                  w_kill_sum;
    logic [OCC_W-1:0]             w_occ;

    // Hold ripples upstream from the consumer; flush deliberately plays no part.
    always_comb begin : p_hold
        logic w_h;
        w_hold         = '0;
        w_h            = stall[STAGES-1] | (r_valid[STAGES-1] & ~out_ready);
        w_hold[STAGES-1] = w_h;
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_h       = stall[i] | (r_valid[i] & w_h);
            w_hold[i] = w_h;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             w_load_valid;
        logic [WIDTH-1:0] w_load_data;
        logic             w_nv;
        logic [WIDTH-1:0] w_nd;

        if (gi == 0) begin : g_head
            assign w_load_valid = in_valid;
            assign w_load_data  = in_data;
        end else begin : g_body
            assign w_load_valid = r_valid[gi-1] & ~w_hold[gi-1] & ~flush[gi-1];
            assign w_load_data  = r_data[gi-1];
        end

        always_comb begin
            w_nv = r_valid[gi];
            w_nd = r_data[gi];
            if (flush[gi]) begin
                w_nv = 1'b0;
            end else if (!w_hold[gi]) begin
                w_nv = w_load_valid;
                w_nd = w_load_data;
            end
            if ((ZERO_INVALID != 0) && !w_nv) begin
                w_nd = '0;
            end
        end

        assign w_next_valid[gi] = w_nv;
        assign w_next_data[gi]  = w_nd;
    end

    always_comb begin
        w_kill_num = '0;
        w_occ      = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_kill_num = w_kill_num + 5'(flush[i] & r_valid[i]);
            w_occ      = w_occ + OCC_W'(r_valid[i]);
        end
        w_kill_sum  = {1'b0, r_kill_count} + {12'd0, w_kill_num};
        w_next_kill = w_kill_sum[16] ? 16'hFFFF : w_kill_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= '0;
            r_data       <= '0;
            r_kill_count <= '0;
        end else begin
            r_valid      <= w_next_valid;
            r_data       <= w_next_data;
            r_kill_count <= w_next_kill;
        end
    end

    assign in_ready    = ~w_hold[0];
    assign stage_valid = r_valid;
    assign stage_data  = r_data;
    assign occupancy   = w_occ;
    assign kill_count  = r_kill_count;

endmodule
`default_nettype wire

// File: tb/tb_pip_reg_chain.sv
`default_nettype none
// tb_pip_reg_chain: directed scenarios plus randomized traffic on pip_reg_chain
// (WIDTH=8, STAGES=3), checked every cycle against a slot-level pipeline model.
module tb_pip_reg_chain;
    localparam int W = 8;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [S-1:0]   stall;
    logic [S-1:0]   flush;
    logic           out_ready;
    logic [S*W-1:0] stage_data;
    logic [S-1:0]   stage_valid;
    logic [1:0]     occupancy;
    logic [15:0]    kill_count;

    int n_cmp = 0;
    int n_bad = 0;

    bit           m_v [S];
    logic [W-1:0] m_d [S];
    int           m_kill = 0;

    pip_reg_chain #(.WIDTH(W), .STAGES(S), .ZERO_INVALID(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .out_ready  (out_ready),
        .stage_data (stage_data),
        .stage_valid(stage_valid),
        .occupancy  (occupancy),
        .kill_count (kill_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A slot keeps its entry when stalled, or when occupied and the slot it feeds is stuck.
    function automatic logic [S-1:0] blocked_set();
        logic [S-1:0] b;
        bit stuck;
        stuck = !out_ready;
        for (int i = S - 1; i >= 0; i--) begin
            b[i]  = stall[i] || (m_v[i] && stuck);
            stuck = b[i];
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_kill = 0;
    endtask

    task automatic model_edge();
        logic [S-1:0] b;
        bit           up_v, offer_v, nv;
        logic [W-1:0] up_d, offer_d, nd;
        int           killed;
        b       = blocked_set();
        up_v    = in_valid;
        up_d    = in_data;
        killed  = 0;
        for (int i = 0; i < S; i++) begin
            offer_v = m_v[i] && !b[i] && !flush[i];
            offer_d = m_d[i];
            if (flush[i] && m_v[i]) killed++;
            if (flush[i])   begin nv = 1'b0;   nd = m_d[i]; end
            else if (b[i])  begin nv = m_v[i]; nd = m_d[i]; end
            else            begin nv = up_v;   nd = up_d;   end
            if (!nv) nd = '0;
            m_v[i] = nv;
            m_d[i] = nd;
            up_v   = offer_v;
            up_d   = offer_d;
        end
        m_kill = m_kill + killed;
        if (m_kill > 65535) m_kill = 65535;
    endtask

    function automatic logic [31:0] exp_valid();
        logic [31:0] v = '0;
        for (int i = 0; i < S; i++) v[i] = m_v[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] f = '0;
        for (int i = 0; i < S; i++) f[i*W +: W] = m_d[i];
        return f;
    endfunction

    function automatic logic [31:0] exp_occ();
        int n = 0;
        for (int i = 0; i < S; i++) n += int'(m_v[i]);
        return 32'(n);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    initial begin
        logic [S-1:0] bs;
        forever begin
            @(negedge clk);
            bs = blocked_set();
            check("m_valid",     32'(stage_valid), exp_valid());
            check("m_data",      32'(stage_data),  exp_data());
            check("m_occupancy", 32'(occupancy),   exp_occ());
            check("m_kill",      32'(kill_count),  32'(m_kill));
            check("m_in_ready",  32'(in_ready),    32'(!bs[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b1;
    endtask

    task automatic reset_pulse();
        tick(); rst_n = 1'b0; idle_inputs();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset state, and in_ready tracking stall[0] while in reset.
        tick();
        at_neg();
        check("rst_valid", 32'(stage_valid), 32'h0);
        check("rst_data",  32'(stage_data),  32'h0);
        check("rst_occ",   32'(occupancy),   32'h0);
        check("rst_kill",  32'(kill_count),  32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        tick(); stall = 3'b001;
        at_neg();
        check("rst_in_ready_stalled", 32'(in_ready), 32'h0);

        // Stream 11,22,33,44; first load on first edge with rst_n high.
        tick(); stall = '0; rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick(); in_data = 8'h22;
        at_neg();
        check("first_load", 32'(stage_data), 32'h000011);
        tick(); in_data = 8'h33;
        tick(); in_data = 8'h44;
        at_neg();
        check("stream_edge3_data",  32'(stage_data),  32'h112233);
        check("stream_edge3_valid", 32'(stage_valid), 32'h7);
        tick(); in_valid = 1'b0;
        at_neg();
        check("stream_edge4_data", 32'(stage_data), 32'h223344);

        // Middle-stage stall on a full pipe.
        reset_pulse();
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick(); in_data = 8'h22;
        tick(); in_data = 8'h33;
        tick(); in_data = 8'h44; stall = 3'b010;
        at_neg();
        check("stall_in_ready", 32'(in_ready), 32'h0);
        tick(); stall = '0; in_valid = 1'b0;
        at_neg();
        check("stall_valid", 32'(stage_valid), 32'h3);
        check("stall_data",  32'(stage_data),  32'h002233);

        // Bubble collapse, then flush vs stall on the same stage.
        reset_pulse();
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        tick(); in_valid = 1'b0;
        tick(); in_valid = 1'b1; in_data = 8'hBB;
        tick(); in_valid = 1'b0; out_ready = 1'b0;
        at_neg();
        check("bubble_pre_data", 32'(stage_data), 32'hAA00BB);
        tick(); in_valid = 1'b1; in_data = 8'hCC;
        at_neg();
        check("bubble_valid", 32'(stage_valid), 32'h6);
        check("bubble_data",  32'(stage_data),  32'hAABB00);
        check("bubble_occ",   32'(occupancy),   32'h2);
        check("bubble_in_ready", 32'(in_ready), 32'h1);
        tick(); flush = 3'b010; stall = 3'b010; in_data = 8'hDD;
        at_neg();
        check("fvs_pre_in_ready", 32'(in_ready), 32'h0);
        tick(); flush = '0; stall = '0; in_data = 8'hEE;
        at_neg();
        check("fvs_valid", 32'(stage_valid), 32'h5);
        check("fvs_data",  32'(stage_data),  32'hAA00CC);
        check("fvs_kill",  32'(kill_count),  32'h1);

        // Kill counter saturation from a preloaded value.
        tick();
        force dut.r_kill_count = 16'hFFFE;
        m_kill = 32'hFFFE;
        #1;
        release dut.r_kill_count;
        flush = 3'b111; in_valid = 1'b0;
        at_neg();
        check("sat_preload", 32'(kill_count), 32'hFFFE);
        check("sat_full",    32'(stage_data), 32'hAACCEE);
        tick(); flush = '0; in_valid = 1'b1; in_data = 8'h12; out_ready = 1'b1;
        at_neg();
        check("sat_kill",  32'(kill_count),  32'hFFFF);
        check("sat_valid", 32'(stage_valid), 32'h0);
        tick(); flush = 3'b001;
        tick(); flush = '0;
        at_neg();
        check("sat_hold", 32'(kill_count), 32'hFFFF);
        check("drop_flushed_input", 32'(stage_valid), 32'h0);

        // Reset mid-stream: everything cleared at once, no kills recorded.
        tick();
        tick(); rst_n = 1'b0;
        at_neg();
        check("midrst_valid", 32'(stage_valid), 32'h0);
        check("midrst_data",  32'(stage_data),  32'h0);
        check("midrst_kill",  32'(kill_count),  32'h0);
        check("midrst_occ",   32'(occupancy),   32'h0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < S; i++) begin
                stall[i] = ($urandom_range(0, 9) == 0);
                flush[i] = ($urandom_range(0, 15) == 0);
            end
        end

        tick(); rst_n = 1'b1; idle_inputs();
        at_neg();
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
